// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt sequencer slice.
package intr_pkg;

    localparam int unsigned N_LINES = 8;
    localparam int unsigned IDX_W   = 3;

    typedef logic [N_LINES-1:0] line_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTER,
        ST_EXIT,
        ST_SETTLE
    } state_e;

    // Position of the set bit in a one-hot line vector (0 when empty).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input line_vec_t v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(N_LINES); i++) begin
            if (v[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_sequencer_if.sv
// Signals between the interrupt manager / CPU control and the sequencer.
interface intr_sequencer_if #(
    parameter int unsigned PC_W = 10
);
    logic [intr_pkg::N_LINES-1:0] min_bit_s;
    logic [intr_pkg::N_LINES-1:0] min_bit_a;
    logic                         intr_enable;
    logic                         instr_done;
    logic                         reti;
    logic [PC_W-1:0]              pc_next;

    logic [intr_pkg::N_LINES-1:0] call_intr;
    logic [intr_pkg::N_LINES-1:0] s_return_intr;
    logic                         pc_load;
    logic [PC_W-1:0]              pc_target;
    logic                         stall;
    logic                         err;

    modport master (
        output min_bit_s, min_bit_a, intr_enable, instr_done, reti, pc_next,
        input  call_intr, s_return_intr, pc_load, pc_target, stall, err
    );

    modport slave (
        input  min_bit_s, min_bit_a, intr_enable, instr_done, reti, pc_next,
        output call_intr, s_return_intr, pc_load, pc_target, stall, err
    );
endinterface

// File: rtl/intr_ret_stack.sv
// Return-address LIFO; only the pointer is reset, contents are don't-care when empty.
module intr_ret_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr_q;

    assign full  = (ptr_q == PTR_W'(DEPTH));
    assign empty = (ptr_q == '0);
    assign dout  = mem[IDX_W'(ptr_q - PTR_W'(1))];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (push && !full) begin
            ptr_q <= ptr_q + PTR_W'(1);
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[IDX_W'(ptr_q)] <= din;
    end

endmodule

// File: rtl/intr_sequencer.sv
// Decides ISR entry/exit from the manager's lowest-bit vectors, drives PC redirects
// and keeps return addresses on a hardware stack.
module intr_sequencer
    import intr_pkg::*;
#(
    parameter int unsigned     PC_W       = 10,
    parameter logic [PC_W-1:0] VEC_BASE   = 10'h3C0,
    parameter int unsigned     VEC_STRIDE = 2,
    parameter int unsigned     DEPTH      = 8
) (
    input  logic             clk,
    input  logic             reset,
    intr_sequencer_if.slave  bus
);
    state_e          state_q, state_d;
    line_vec_t       call_q, call_d;
    line_vec_t       sret_q, sret_d;
    logic            load_q, load_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            stall_q, stall_d;
    logic            err_q, err_d;
    logic [PC_W-1:0] ret_pc_q, ret_pc_d;

    logic            stk_push, stk_pop, stk_full, stk_empty;
    logic [PC_W-1:0] stk_dout;
    logic            take;
    logic [PC_W-1:0] vec_addr;

    // One-hot vectors: a smaller value is a strictly higher-priority line.
    assign take = bus.instr_done && bus.intr_enable && (bus.min_bit_s != '0) &&
                  ((bus.min_bit_a == '0) || (bus.min_bit_s < bus.min_bit_a));

    assign vec_addr = VEC_BASE + PC_W'(onehot_to_idx(bus.min_bit_s)) * PC_W'(VEC_STRIDE);

    assign stk_push = (state_q == ST_ENTER);
    assign stk_pop  = (state_q == ST_EXIT);

    intr_ret_stack #(
        .DEPTH (DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (ret_pc_q),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Outputs are computed for the state being entered and registered with it.
    always_comb begin
        state_d  = state_q;
        call_d   = '0;
        sret_d   = '0;
        load_d   = 1'b0;
        stall_d  = 1'b0;
        target_d = target_q;
        err_d    = err_q;
        ret_pc_d = ret_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_done && bus.reti) begin
                    stall_d = 1'b1;
                    if (stk_empty) begin
                        err_d   = 1'b1;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d  = ST_EXIT;
                        sret_d   = bus.min_bit_a;
                        load_d   = 1'b1;
                        target_d = stk_dout;
                    end
                end else if (take) begin
                    state_d  = ST_ENTER;
                    call_d   = bus.min_bit_s;
                    load_d   = 1'b1;
                    stall_d  = 1'b1;
                    target_d = vec_addr;
                    ret_pc_d = bus.pc_next;
                end
            end
            ST_ENTER: begin
                state_d = ST_SETTLE;
                stall_d = 1'b1;
                if (stk_full) err_d = 1'b1;
            end
            ST_EXIT: begin
                state_d = ST_SETTLE;
                stall_d = 1'b1;
            end
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            call_q   <= '0;
            sret_q   <= '0;
            load_q   <= 1'b0;
            target_q <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
            ret_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            call_q   <= call_d;
            sret_q   <= sret_d;
            load_q   <= load_d;
            target_q <= target_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
            ret_pc_q <= ret_pc_d;
        end
    end

    assign bus.call_intr     = call_q;
    assign bus.s_return_intr = sret_q;
    assign bus.pc_load       = load_q;
    assign bus.pc_target     = target_q;
    assign bus.stall         = stall_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_intr_sequencer.sv
// Directed table plus hand-written corner sequences for intr_sequencer.
module tb_intr_sequencer;

    typedef struct packed {
        logic       rst;
        logic [7:0] s;
        logic [7:0] a;
        logic       en;
        logic       done;
        logic       reti;
        logic [9:0] pc;
    } in_t;

    typedef struct packed {
        logic [7:0] call;
        logic [7:0] sret;
        logic       load;
        logic [9:0] target;
        logic       stall;
        logic       err;
    } outs_t;

    typedef struct packed {
        in_t   i;
        outs_t o;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    int   ncmp = 0;
    int   nbad = 0;
    rec_t tbl[$];

    intr_sequencer_if #(.PC_W(10)) bus ();

    intr_sequencer #(
        .PC_W       (10),
        .VEC_BASE   (10'h3C0),
        .VEC_STRIDE (2),
        .DEPTH      (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(input logic r, input logic [7:0] s, input logic [7:0] a,
                                input logic en, input logic d, input logic rt,
                                input logic [9:0] pc, input logic [7:0] c,
                                input logic [7:0] sr, input logic ld,
                                input logic [9:0] t, input logic st, input logic er);
        rec_t x;
        x.i = '{rst: r, s: s, a: a, en: en, done: d, reti: rt, pc: pc};
        x.o = '{call: c, sret: sr, load: ld, target: t, stall: st, err: er};
        return x;
    endfunction

    function automatic in_t idle_in();
        return '{rst: 1'b0, s: 8'h00, a: 8'h00, en: 1'b1, done: 1'b0, reti: 1'b0, pc: 10'h000};
    endfunction

    function automatic outs_t o_mk(input logic [7:0] c, input logic [7:0] sr, input logic ld,
                                   input logic [9:0] t, input logic st, input logic er);
        return '{call: c, sret: sr, load: ld, target: t, stall: st, err: er};
    endfunction

    task automatic apply(input in_t v);
        reset           = v.rst;
        bus.min_bit_s   = v.s;
        bus.min_bit_a   = v.a;
        bus.intr_enable = v.en;
        bus.instr_done  = v.done;
        bus.reti        = v.reti;
        bus.pc_next     = v.pc;
    endtask

    task automatic check(input string nm, input outs_t exp);
        outs_t act;
        act = {bus.call_intr, bus.s_return_intr, bus.pc_load, bus.pc_target, bus.stall, bus.err};
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got call=%h sret=%h load=%b target=%h stall=%b err=%b, want call=%h sret=%h load=%b target=%h stall=%b err=%b",
                     nm, act.call, act.sret, act.load, act.target, act.stall, act.err,
                     exp.call, exp.sret, exp.load, exp.target, exp.stall, exp.err);
        end
    endtask

    // Drive inputs just after an edge, then compare just after the next edge.
    task automatic step(input string nm, input in_t v, input outs_t exp);
        apply(v);
        @(posedge clk);
        #1;
        check(nm, exp);
    endtask

    initial begin
        in_t v;
        apply(idle_in());
        reset = 1'b1;

        //             r  s      a      en    d     rt    pc       call   sret   ld    target   st    err
        tbl.push_back(mk(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0));
        // single entry on line 2
        tbl.push_back(mk(0, 8'h04, 8'h00, 1'b1, 1'b1, 1'b0, 10'h012, 8'h04, 8'h00, 1'b1, 10'h3C4, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h3C4, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h3C4, 1'b0, 1'b0));
        // nested entry on line 0 while line 2 is in service
        tbl.push_back(mk(0, 8'h01, 8'h04, 1'b1, 1'b1, 1'b0, 10'h050, 8'h01, 8'h00, 1'b1, 10'h3C0, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h3C0, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h3C0, 1'b0, 1'b0));
        // lower priority, disabled, and equal-to-in-service: no entry
        tbl.push_back(mk(0, 8'h10, 8'h04, 1'b1, 1'b1, 1'b0, 10'h060, 8'h00, 8'h00, 1'b0, 10'h3C0, 1'b0, 1'b0));
        tbl.push_back(mk(0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 10'h060, 8'h00, 8'h00, 1'b0, 10'h3C0, 1'b0, 1'b0));
        tbl.push_back(mk(0, 8'h04, 8'h04, 1'b1, 1'b1, 1'b0, 10'h060, 8'h00, 8'h00, 1'b0, 10'h3C0, 1'b0, 1'b0));
        // two returns in LIFO order
        tbl.push_back(mk(0, 8'h00, 8'h01, 1'b1, 1'b1, 1'b1, 10'h070, 8'h00, 8'h01, 1'b1, 10'h050, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h050, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h050, 1'b0, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h04, 1'b1, 1'b1, 1'b1, 10'h070, 8'h00, 8'h04, 1'b1, 10'h012, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h012, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h012, 1'b0, 1'b0));
        // entry on line 3, then RETI racing a take on line 1
        tbl.push_back(mk(0, 8'h08, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0AA, 8'h08, 8'h00, 1'b1, 10'h3C6, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h3C6, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h3C6, 1'b0, 1'b0));
        tbl.push_back(mk(0, 8'h02, 8'h08, 1'b1, 1'b1, 1'b1, 10'h0AC, 8'h00, 8'h08, 1'b1, 10'h0AA, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h02, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0B0, 8'h00, 8'h00, 1'b0, 10'h0AA, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h02, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0B0, 8'h00, 8'h00, 1'b0, 10'h0AA, 1'b0, 1'b0));
        tbl.push_back(mk(0, 8'h02, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0B0, 8'h02, 8'h00, 1'b1, 10'h3C2, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h3C2, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h3C2, 1'b0, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h02, 1'b1, 1'b1, 1'b1, 10'h0C0, 8'h00, 8'h02, 1'b1, 10'h0B0, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h0B0, 1'b1, 1'b0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 1'b0, 10'h0B0, 1'b0, 1'b0));

        @(posedge clk);
        #1;
        foreach (tbl[k]) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);

        // RETI on an empty stack: error, no load, one stall cycle
        v = idle_in(); v.done = 1'b1; v.reti = 1'b1; v.a = 8'h01;
        step("underflow", v, o_mk(8'h00, 8'h00, 1'b0, 10'h0B0, 1'b1, 1'b1));
        step("underflow_idle", idle_in(), o_mk(8'h00, 8'h00, 1'b0, 10'h0B0, 1'b0, 1'b1));
        v = idle_in(); v.rst = 1'b1;
        step("reset_clears_err", v, o_mk(8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0));

        // nine nested entries: the ninth push is dropped and flags an error
        for (int n = 0; n < 9; n++) begin
            v = idle_in(); v.s = 8'h01; v.done = 1'b1; v.pc = 10'h100 + 10'(n);
            step($sformatf("push%0d", n), v, o_mk(8'h01, 8'h00, 1'b1, 10'h3C0, 1'b1, 1'b0));
            step($sformatf("push%0d_settle", n), idle_in(),
                 o_mk(8'h00, 8'h00, 1'b0, 10'h3C0, 1'b1, (n == 8)));
            step($sformatf("push%0d_idle", n), idle_in(),
                 o_mk(8'h00, 8'h00, 1'b0, 10'h3C0, 1'b0, (n == 8)));
        end
        // pops with nothing in service: PC reloads, no end-of-service pulse
        for (int n = 0; n < 8; n++) begin
            v = idle_in(); v.done = 1'b1; v.reti = 1'b1;
            step($sformatf("pop%0d", n), v, o_mk(8'h00, 8'h00, 1'b1, 10'h107 - 10'(n), 1'b1, 1'b1));
            step($sformatf("pop%0d_settle", n), idle_in(),
                 o_mk(8'h00, 8'h00, 1'b0, 10'h107 - 10'(n), 1'b1, 1'b1));
            step($sformatf("pop%0d_idle", n), idle_in(),
                 o_mk(8'h00, 8'h00, 1'b0, 10'h107 - 10'(n), 1'b0, 1'b1));
        end

        // reset on the edge that would start ENTER suppresses the pulse
        v = idle_in(); v.rst = 1'b1; v.s = 8'h01; v.done = 1'b1; v.pc = 10'h1FF;
        step("rst_with_take", v, o_mk(8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0));
        step("rst_release", idle_in(), o_mk(8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0));
        // reset while in ENTER: sequence aborted and the pending push is lost
        v = idle_in(); v.s = 8'h01; v.done = 1'b1; v.pc = 10'h1FF;
        step("enter_before_rst", v, o_mk(8'h01, 8'h00, 1'b1, 10'h3C0, 1'b1, 1'b0));
        v = idle_in(); v.rst = 1'b1;
        step("rst_in_enter", v, o_mk(8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0));
        step("rst_in_enter_idle", idle_in(), o_mk(8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0));
        v = idle_in(); v.done = 1'b1; v.reti = 1'b1; v.a = 8'h01;
        step("stack_empty_after_rst", v, o_mk(8'h00, 8'h00, 1'b0, 10'h000, 1'b1, 1'b1));

        $display("test done: total=%0d bad=%0d", ncmp, nbad);
        $finish;
    end

endmodule
